// File: rtl/matmul_stream_engine_if.sv
// Bus bundle for matmul_stream_engine: job control, operand RAM read ports, result stream.
// err_sat exists only when MMS_SATURATE_EN is defined.
interface matmul_stream_engine_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int LANES  = 4,
  parameter int DIM_W  = 8
);
  logic                      start;
  logic [DIM_W-1:0]          m_dim;
  logic [DIM_W-1:0]          k_dim;
  logic [DIM_W-1:0]          n_dim;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic                      a_rd_en;
  logic [2*DIM_W-1:0]        a_addr;
  logic [DATA_W-1:0]         a_rd_data;
  logic                      b_rd_en;
  logic [2*DIM_W-1:0]        b_addr;
  logic [LANES*DATA_W-1:0]   b_rd_data;
  // Result stream: a beat transfers on a cycle with c_valid && c_ready; once
  // c_valid rises, data/row/colgrp/mask/last hold steady until that cycle.
  logic                      c_valid;
  logic                      c_ready;
  logic [LANES*OUT_W-1:0]    c_data;
  logic [DIM_W-1:0]          c_row;
  logic [DIM_W-1:0]          c_colgrp;
  logic [LANES-1:0]          c_lane_mask;
  logic                      c_last;
`ifdef MMS_SATURATE_EN
  logic                      err_sat;
`endif

  modport master (
`ifdef MMS_SATURATE_EN
    output err_sat,
`endif
    input  start, m_dim, k_dim, n_dim, a_rd_data, b_rd_data, c_ready,
    output busy, done, err, a_rd_en, a_addr, b_rd_en, b_addr,
    output c_valid, c_data, c_row, c_colgrp, c_lane_mask, c_last
  );

  modport slave (
`ifdef MMS_SATURATE_EN
    input  err_sat,
`endif
    output start, m_dim, k_dim, n_dim, a_rd_data, b_rd_data, c_ready,
    input  busy, done, err, a_rd_en, a_addr, b_rd_en, b_addr,
    input  c_valid, c_data, c_row, c_colgrp, c_lane_mask, c_last
  );
endinterface

// File: rtl/matmul_stream_engine.sv
// Signed fixed-point C = A x B streaming engine, LANES output columns per tile.
// MMS_SATURATE_EN selects clamped outputs plus the err_sat flag; otherwise lanes wrap.
module matmul_stream_engine #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 32,
  parameter int LANES   = 4,
  parameter int MAX_DIM = 64,
  parameter int DIM_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  matmul_stream_engine_if.master bus,
  output logic [2:0]            dbg_state_o
);
  localparam int AW = 2 * DIM_W;
  localparam logic [DIM_W-1:0] MAX_C = DIM_W'(MAX_DIM);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MAC   = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic [DIM_W-1:0] m_dim_q, k_dim_q, n_dim_q;
  logic [DIM_W-1:0] i_q, i_d, g_q, g_d, k_idx_q, k_idx_d;
  logic             err_q, err_d;
  logic             mac_vld_q;
  logic signed [ACC_W-1:0] acc_q [LANES];

  logic cap, clr_acc, rd_en, busy, done, err, c_valid, is_last;
  logic [DIM_W:0]   ng;
  logic [DIM_W-1:0] ng_last;
  logic             dims_ok;

  assign ng      = ({1'b0, n_dim_q} + (DIM_W+1)'(LANES - 1)) / (DIM_W+1)'(LANES);
  assign ng_last = DIM_W'(ng - 1'b1);
  assign dims_ok = (m_dim_q != '0) && (m_dim_q <= MAX_C) &&
                   (k_dim_q != '0) && (k_dim_q <= MAX_C) &&
                   (n_dim_q != '0) && (n_dim_q <= MAX_C);
  assign is_last = (i_q == DIM_W'(m_dim_q - 1'b1)) && (g_q == ng_last);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    g_d     = g_q;
    k_idx_d = k_idx_q;
    err_d   = err_q;
    cap     = 1'b0;
    clr_acc = 1'b0;
    rd_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    c_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cap     = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy    = 1'b1;
        i_d     = '0;
        g_d     = '0;
        k_idx_d = '0;
        err_d   = !dims_ok;
        clr_acc = dims_ok;
        state_d = dims_ok ? S_MAC : S_FIN;
      end
      S_MAC: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (k_idx_q == DIM_W'(k_dim_q - 1'b1)) begin
          k_idx_d = '0;
          state_d = S_WAIT;
        end else begin
          k_idx_d = k_idx_q + 1'b1;
        end
      end
      S_WAIT: begin
        busy    = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        busy    = 1'b1;
        c_valid = 1'b1;
        if (bus.c_ready) begin
          if (is_last) begin
            state_d = S_FIN;
          end else begin
            clr_acc = 1'b1;
            state_d = S_MAC;
            if (g_q == ng_last) begin
              g_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              g_d = g_q + 1'b1;
            end
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Products of the operands returned by last cycle's read.
  logic signed [2*DATA_W-1:0] prod     [LANES];
  logic signed [ACC_W-1:0]    prod_ext [LANES];
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l]     = $signed(bus.a_rd_data) * $signed(bus.b_rd_data[l*DATA_W +: DATA_W]);
      prod_ext[l] = ACC_W'(prod[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_dim_q   <= '0;
      k_dim_q   <= '0;
      n_dim_q   <= '0;
      i_q       <= '0;
      g_q       <= '0;
      k_idx_q   <= '0;
      err_q     <= 1'b0;
      mac_vld_q <= 1'b0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      g_q       <= g_d;
      k_idx_q   <= k_idx_d;
      err_q     <= err_d;
      mac_vld_q <= rd_en;
      if (cap) begin
        m_dim_q <= bus.m_dim;
        k_dim_q <= bus.k_dim;
        n_dim_q <= bus.n_dim;
      end
      for (int l = 0; l < LANES; l++) begin
        if (clr_acc)        acc_q[l] <= '0;
        else if (mac_vld_q) acc_q[l] <= acc_q[l] + prod_ext[l];
      end
    end
  end

  logic [LANES-1:0]       mask;
  logic [LANES*OUT_W-1:0] c_data_w;
`ifdef MMS_SATURATE_EN
  logic [LANES-1:0]       clip;
`else
  logic                   unused_acc_hi;
`endif
  always_comb begin
    logic [OUT_W-1:0] lv;
    mask     = '0;
    c_data_w = '0;
`ifdef MMS_SATURATE_EN
    clip     = '0;
`else
    unused_acc_hi = 1'b0;
`endif
    for (int l = 0; l < LANES; l++) begin
      mask[l] = (AW'(g_q) * AW'(LANES) + AW'(l)) < AW'(n_dim_q);
      lv      = acc_q[l][OUT_W-1:0];
`ifdef MMS_SATURATE_EN
      // Out of range whenever the bits above the output sign bit disagree with the acc sign.
      if (acc_q[l][ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){acc_q[l][ACC_W-1]}}) begin
        clip[l] = mask[l];
        lv      = acc_q[l][ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
`else
      unused_acc_hi = unused_acc_hi ^ (^acc_q[l][ACC_W-1:OUT_W]);
`endif
      if (mask[l]) c_data_w[l*OUT_W +: OUT_W] = lv;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.err         = err;
  assign bus.a_rd_en     = rd_en;
  assign bus.b_rd_en     = rd_en;
  assign bus.a_addr      = rd_en ? AW'(i_q) * AW'(k_dim_q) + AW'(k_idx_q) : '0;
  assign bus.b_addr      = rd_en ? AW'(k_idx_q) * AW'(ng) + AW'(g_q) : '0;
  assign bus.c_valid     = c_valid;
  assign bus.c_data      = c_valid ? c_data_w : '0;
  assign bus.c_row       = c_valid ? i_q : '0;
  assign bus.c_colgrp    = c_valid ? g_q : '0;
  assign bus.c_lane_mask = c_valid ? mask : '0;
  assign bus.c_last      = c_valid && is_last;
`ifdef MMS_SATURATE_EN
  assign bus.err_sat     = c_valid && bus.c_ready && (|clip);
`endif
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_matmul_stream_engine.sv
// Directed + randomized bench for matmul_stream_engine with a plain-arithmetic golden model.
// Build with +define+MMS_SATURATE_EN to check the clamping variant.
module tb_matmul_stream_engine;
  localparam int DATA_W  = 16;
  localparam int ACC_W   = 40;
  localparam int OUT_W   = 32;
  localparam int LANES   = 4;
  localparam int MAX_DIM = 64;
  localparam int DIM_W   = 8;
  localparam int BW      = LANES*OUT_W + 2*DIM_W + LANES + 1;
  localparam int CW      = 160;
  localparam int BUDGET  = 20000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_stream_engine_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .LANES(LANES), .DIM_W(DIM_W)) bus ();
  logic [2:0] dbg_state;

  matmul_stream_engine #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .LANES(LANES), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
  );

  // operand RAMs with one-cycle read latency
  logic [DATA_W-1:0]       a_mem [0:4095];
  logic [LANES*DATA_W-1:0] b_mem [0:4095];
  always @(posedge clk) begin
    if (bus.a_rd_en) bus.a_rd_data <= a_mem[bus.a_addr[11:0]];
    if (bus.b_rd_en) bus.b_rd_data <= b_mem[bus.b_addr[11:0]];
  end

  int A_m [64][64];
  int B_m [64][64];
  logic [BW-1:0] exp_q[$];
  bit            exp_sat_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] lane_ref(input longint s);
`ifdef MMS_SATURATE_EN
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[OUT_W-1:0];
  endfunction

  function automatic bit lane_clip(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic fill_random(input int m, input int k, input int n);
    for (int i = 0; i < m; i++)
      for (int kk = 0; kk < k; kk++) A_m[i][kk] = int'($urandom_range(0, 65535)) - 32768;
    for (int kk = 0; kk < k; kk++)
      for (int j = 0; j < n; j++) B_m[kk][j] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  // Loads the RAMs from A_m/B_m and queues the expected beats in tile order.
  task automatic build_ref(input int m, input int k, input int n);
    int ng;
    ng = (n + LANES - 1) / LANES;
    for (int i = 0; i < m; i++)
      for (int kk = 0; kk < k; kk++) a_mem[i*k + kk] = DATA_W'(A_m[i][kk]);
    for (int kk = 0; kk < k; kk++)
      for (int g = 0; g < ng; g++)
        for (int l = 0; l < LANES; l++)
          b_mem[kk*ng + g][l*DATA_W +: DATA_W] = (g*LANES + l < n) ?
              DATA_W'(B_m[kk][g*LANES + l]) : DATA_W'($urandom_range(0, 65535));
    for (int i = 0; i < m; i++) begin
      for (int g = 0; g < ng; g++) begin
        logic [LANES*OUT_W-1:0] d;
        logic [LANES-1:0]       msk;
        bit                     sat;
        d = '0; msk = '0; sat = 1'b0;
        for (int l = 0; l < LANES; l++) begin
          int col;
          longint s;
          col = g*LANES + l;
          if (col < n) begin
            s = 0;
            for (int kk = 0; kk < k; kk++) s += longint'(A_m[i][kk]) * longint'(B_m[kk][col]);
            d[l*OUT_W +: OUT_W] = lane_ref(s);
            msk[l] = 1'b1;
            if (lane_clip(s)) sat = 1'b1;
          end
        end
        exp_q.push_back({d, DIM_W'(i), DIM_W'(g), msk, (i == m-1) && (g == ng-1)});
        exp_sat_q.push_back(sat);
      end
    end
  endtask

  // driver + monitor for one job; stall_beat >= 0 holds c_ready low 10 cycles on that beat
  task automatic run_job(input string tag, input int m, input int k, input int n,
                         input int ready_pct, input int stall_beat, input bit expect_err);
    int cyc, beats, stall, last_hs, ng;
    bit done_seen, rd_seen;
    logic [BW-1:0] obs;
    cyc = 1; beats = 0; stall = 0; last_hs = -1; done_seen = 0; rd_seen = 0;
    ng = (n + LANES - 1) / LANES;
    @(negedge clk);
    bus.m_dim = DIM_W'(m); bus.k_dim = DIM_W'(k); bus.n_dim = DIM_W'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!done_seen && cyc < BUDGET) begin
      if (bus.a_rd_en || bus.b_rd_en) rd_seen = 1'b1;
      if (bus.c_valid && beats == stall_beat && stall < 10) begin
        bus.c_ready = 1'b0;
        stall++;
        #1;
        obs = {bus.c_data, bus.c_row, bus.c_colgrp, bus.c_lane_mask, bus.c_last};
        chk({tag, "_stall_beat"}, CW'(obs), CW'(exp_q.size() > 0 ? exp_q[0] : '0));
        chk({tag, "_stall_busy_rd"}, CW'({bus.busy, bus.a_rd_en, bus.b_rd_en}), CW'(3'b100));
      end else begin
        bus.c_ready = ($urandom_range(1, 100) <= ready_pct);
        #1;
      end
      if (bus.c_valid && bus.c_ready) begin
        obs = {bus.c_data, bus.c_row, bus.c_colgrp, bus.c_lane_mask, bus.c_last};
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_beat"}, CW'(1), CW'(0));
        end else begin
          chk($sformatf("%s_beat%0d", tag, beats), CW'(obs), CW'(exp_q.pop_front()));
`ifdef MMS_SATURATE_EN
          chk($sformatf("%s_err_sat%0d", tag, beats), CW'(bus.err_sat), CW'(exp_sat_q[0]));
`endif
          void'(exp_sat_q.pop_front());
        end
        beats++;
        last_hs = cyc;
      end
      if (bus.done) begin
        done_seen = 1'b1;
        chk({tag, "_err"}, CW'(bus.err), CW'(expect_err));
        chk({tag, "_busy_at_done"}, CW'(bus.busy), CW'(0));
        if (expect_err)
          chk({tag, "_err_latency"}, CW'(cyc), CW'(2));
        else if (ready_pct == 100 && stall_beat < 0)
          chk({tag, "_job_latency"}, CW'(cyc), CW'(m*ng*(k+2) + 2));
        else
          chk({tag, "_done_after_last"}, CW'(cyc), CW'(last_hs + 1));
      end
      @(negedge clk);
      cyc++;
    end
    bus.c_ready = 1'b0;
    chk({tag, "_done_seen"}, CW'(done_seen), CW'(1));
    chk({tag, "_beats_left"}, CW'(exp_q.size()), CW'(0));
    if (expect_err) chk({tag, "_no_reads"}, CW'(rd_seen), CW'(0));
    exp_q.delete();
    exp_sat_q.delete();
  endtask

  initial begin
    int m, k, n, waited;
    bus.start = 1'b0; bus.c_ready = 1'b0;
    bus.m_dim = '0; bus.k_dim = '0; bus.n_dim = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", CW'({bus.busy, bus.done, bus.err, bus.a_rd_en, bus.b_rd_en}), CW'(0));
    chk("rst_stream", CW'({bus.c_valid, bus.c_last, bus.c_lane_mask, bus.c_row, bus.c_colgrp}), CW'(0));
    chk("rst_data", CW'(bus.c_data), CW'(0));
    chk("rst_addr", CW'({bus.a_addr, bus.b_addr}), CW'(0));
    rst = 1'b0;

    // A=[1 2;3 4], B=I
    A_m[0][0] = 1; A_m[0][1] = 2; A_m[1][0] = 3; A_m[1][1] = 4;
    B_m[0][0] = 1; B_m[0][1] = 0; B_m[1][0] = 0; B_m[1][1] = 1;
    build_ref(2, 2, 2);
    run_job("ident", 2, 2, 2, 100, -1, 1'b0);

    fill_random(3, 5, 6);
    build_ref(3, 5, 6);
    run_job("rand356", 3, 5, 6, 100, -1, 1'b0);

    fill_random(2, 3, 5);
    build_ref(2, 3, 5);
    run_job("stall", 2, 3, 5, 100, 1, 1'b0);

    for (int j = 0; j < 4; j++) begin
      m = $urandom_range(1, 6); k = $urandom_range(1, 8); n = $urandom_range(1, 9);
      fill_random(m, k, n);
      build_ref(m, k, n);
      run_job($sformatf("rnd%0d", j), m, k, n, 60, -1, 1'b0);
    end

    fill_random(2, 1, 64);
    build_ref(2, 1, 64);
    run_job("n_max", 2, 1, 64, 100, -1, 1'b0);

    run_job("k_zero", 1, 0, 3, 100, -1, 1'b1);
    run_job("m_over", MAX_DIM + 1, 2, 2, 100, -1, 1'b1);

    // full-scale operands, K=64
    for (int kk = 0; kk < 64; kk++) begin
      A_m[0][kk] = 32'h7FFF;
      for (int j = 0; j < 3; j++) B_m[kk][j] = 32'h7FFF;
    end
    build_ref(1, 64, 3);
    run_job("sat", 1, 64, 3, 100, -1, 1'b0);

    // reset in the middle of a MAC phase, then a clean job
    fill_random(2, 6, 4);
    build_ref(2, 6, 4);
    @(negedge clk);
    bus.m_dim = 8'd2; bus.k_dim = 8'd6; bus.n_dim = 8'd4;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waited = 0;
    while (!bus.a_rd_en && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("midrst_reads_began", CW'(bus.a_rd_en), CW'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_quiet", CW'({bus.busy, bus.c_valid, bus.a_rd_en, bus.b_rd_en, bus.done}), CW'(0));
    rst = 1'b0;
    exp_q.delete();
    exp_sat_q.delete();
    fill_random(2, 4, 3);
    build_ref(2, 4, 3);
    run_job("after_rst", 2, 4, 3, 100, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
